// File: rtl/hier_node_sequencer.sv
// Hierarchy node that launches NUM_CHILDREN children sequentially or in parallel through a
// start/done handshake, with a per-child (sequential) or per-run (parallel) timeout watchdog.
module hier_node_sequencer #(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned TIMEOUT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [TIMEOUT_W-1:0]    timeout_i,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [NUM_CHILDREN-1:0] fail_mask_o
);

  localparam int unsigned IdxW = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHILDREN - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StFinish} state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NUM_CHILDREN-1:0] cap_q, cap_d;
  logic [NUM_CHILDREN-1:0] fail_q, fail_d;

  logic [NUM_CHILDREN-1:0] cap_all;
  logic                    complete;
  logic                    expire;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    tmo_d         = tmo_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    cap_d         = cap_q;
    fail_d        = fail_q;
    child_start_o = '0;
    busy_o        = 1'b0;
    done_o        = 1'b0;

    cap_all  = cap_q | child_done_i;
    complete = mode_q ? (&cap_all) : child_done_i[idx_q];
    // A completion in the expiry cycle wins; timeout 0 disables expiry entirely.
    expire   = (tmo_q != '0) && (cnt_q == tmo_q - TIMEOUT_W'(1)) && !complete;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          tmo_d   = timeout_i;
          fail_d  = '0;
          cap_d   = '0;
          idx_d   = '0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        busy_o        = 1'b1;
        child_start_o = mode_q ? '1 : (NUM_CHILDREN'(1) << idx_q);
        cnt_d         = '0;
        state_d       = StWait;
      end
      StWait: begin
        busy_o = 1'b1;
        cap_d  = cap_all;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
        if (mode_q) begin
          if (complete) begin
            state_d = StFinish;
          end else if (expire) begin
            fail_d  = ~cap_all;
            state_d = StFinish;
          end
        end else if (complete || expire) begin
          if (expire) begin
            fail_d[idx_q] = 1'b1;
          end
          if (idx_q == LastIdx) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StLaunch;
          end
        end
      end
      StFinish: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      fail_q  <= fail_d;
    end
  end

  assign fail_mask_o = fail_q;
  assign error_o     = |fail_q;

endmodule

// File: tb/tb_hier_node_sequencer.sv
// Self-checking bench for hier_node_sequencer: a run-level schedule model checked every cycle,
// plus a two-node cascade checked against hand-computed cycle counts.
module tb_hier_node_sequencer;

  localparam int N  = 5;
  localparam int TW = 8;

  typedef int dly_t [N];

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          mode_i;
  logic [TW-1:0] timeout_i;
  logic [N-1:0]  child_start_o;
  logic [N-1:0]  child_done_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [N-1:0]  fail_mask_o;

  always #5 clk = ~clk;

  hier_node_sequencer #(.NUM_CHILDREN(N), .TIMEOUT_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .timeout_i     (timeout_i),
    .child_start_o (child_start_o),
    .child_done_i  (child_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .fail_mask_o   (fail_mask_o)
  );

  // Cascade: node B hangs off child 1 of node A; A's children 0 and 2 answer with a level.
  logic          cas_start;
  logic [TW-1:0] cas_ta, cas_tb;
  logic [2:0]    b_lvl;
  logic [2:0]    a_cs, a_cd, a_fail, b_cs, b_fail;
  logic          a_busy, a_done, a_err, b_busy, b_done, b_err;

  assign a_cd = {1'b1, b_done, 1'b1};

  hier_node_sequencer #(.NUM_CHILDREN(3), .TIMEOUT_W(TW)) node_a (
    .clk           (clk),
    .rst           (rst),
    .start_i       (cas_start),
    .mode_i        (1'b0),
    .timeout_i     (cas_ta),
    .child_start_o (a_cs),
    .child_done_i  (a_cd),
    .busy_o        (a_busy),
    .done_o        (a_done),
    .error_o       (a_err),
    .fail_mask_o   (a_fail)
  );

  hier_node_sequencer #(.NUM_CHILDREN(3), .TIMEOUT_W(TW)) node_b (
    .clk           (clk),
    .rst           (rst),
    .start_i       (a_cs[1]),
    .mode_i        (1'b0),
    .timeout_i     (cas_tb),
    .child_start_o (b_cs),
    .child_done_i  (b_lvl),
    .busy_o        (b_busy),
    .done_o        (b_done),
    .error_o       (b_err),
    .fail_mask_o   (b_fail)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc    = 0;
  bit checking = 1'b0;

  // Model results, relative to the accept cycle (rel 0).
  int           m_st [N];
  int           m_done;
  logic [N-1:0] m_fail;

  // Responder: child i pulses done dly[i] cycles after its start (negative = never).
  dly_t dly;
  int   pend [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Run-level schedule: each child's wait is its response delay, or the timeout if it is late.
  task automatic model(input bit m, input int t, input dly_t d);
    int  tt;
    int  w;
    bit  resp;
    bit  all_resp;
    m_fail = '0;
    if (!m) begin
      tt = 1;
      for (int i = 0; i < N; i++) begin
        m_st[i] = tt;
        resp = (d[i] >= 1) && (t == 0 || d[i] <= t);
        w = resp ? d[i] : t;
        m_fail[i] = !resp;
        tt = tt + 1 + w;
      end
      m_done = tt;
    end else begin
      all_resp = 1'b1;
      w = 0;
      for (int i = 0; i < N; i++) begin
        m_st[i] = 1;
        resp = (d[i] >= 1) && (t == 0 || d[i] <= t);
        if (!resp) all_resp = 1'b0;
        if (resp && d[i] > w) w = d[i];
        m_fail[i] = !resp;
      end
      if (!all_resp) w = t;
      m_done = 1 + w + 1;
    end
  endtask

  task automatic check_cycle();
    int           rel;
    logic [N-1:0] es;
    rel = cyc - acc;
    for (int i = 0; i < N; i++) es[i] = (m_st[i] == rel);
    chk("child_start", 32'(child_start_o), 32'(es));
    chk("busy", 32'(busy_o), 32'(rel >= 1 && rel < m_done));
    chk("done", 32'(done_o), 32'(rel == m_done));
    if (rel >= m_done) begin
      chk("fail_mask", 32'(fail_mask_o), 32'(m_fail));
      chk("error", 32'(error_o), 32'(|m_fail));
    end
  endtask

  task automatic tick();
    logic [N-1:0] dn;
    @(negedge clk);
    cyc++;
    if (checking) check_cycle();
    for (int i = 0; i < N; i++) begin
      if (child_start_o[i] === 1'b1) pend[i] = (dly[i] < 0) ? -1 : cyc + dly[i];
    end
    for (int i = 0; i < N; i++) dn[i] = (pend[i] == cyc);
    child_done_i = dn;
  endtask

  task automatic begin_run(input bit m, input int t, input dly_t d);
    dly = d;
    for (int i = 0; i < N; i++) pend[i] = -1;
    mode_i    = m;
    timeout_i = TW'(t);
    start_i   = 1'b1;
    acc       = cyc;
  endtask

  task automatic run(input bit m, input int t, input dly_t d, input bit hold,
                     input int lit_done, input logic [N-1:0] lit_fail);
    model(m, t, d);
    chk("model_done_cycle", 32'(m_done), 32'(lit_done));
    chk("model_fail_mask", 32'(m_fail), 32'(lit_fail));
    begin_run(m, t, d);
    checking = 1'b1;
    while (cyc - acc < m_done + 2) begin
      tick();
      // A held start must be ignored through the FINISH cycle.
      if (!hold || cyc - acc > m_done) start_i = 1'b0;
    end
    checking = 1'b0;
  endtask

  task automatic abort_run();
    dly_t d;
    d = '{1, 1, 1, 1, 1};
    model(1'b0, 8, d);
    begin_run(1'b0, 8, d);
    checking = 1'b1;
    while (cyc - acc < 5) begin
      tick();
      start_i = 1'b0;
    end
    checking = 1'b0;
    chk("abort_at_child2", 32'(child_start_o), 32'(5'b00100));
    rst = 1'b1;
    tick();
    chk("rst_child_start", 32'(child_start_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_fail", 32'(fail_mask_o), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_no_done", 32'(done_o), 32'd0);
    chk("post_rst_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic no_timeout_run();
    dly_t         d;
    int           bad;
    logic [N-1:0] launched;
    d = '{1, -1, 1, 1, 1};
    begin_run(1'b0, 0, d);
    bad = 0;
    launched = '0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      start_i = 1'b0;
      if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
      launched = launched | child_start_o;
    end
    chk("no_timeout_bad_cycles", 32'(bad), 32'd0);
    chk("no_timeout_launched", 32'(launched), 32'(5'b00011));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("no_timeout_rst_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic cas_run(input int ta, input int tb, input logic [2:0] lvl,
                         input int lit_done, input logic [2:0] lit_afail,
                         input logic [2:0] lit_bfail);
    int a0;
    int got;
    int na;
    int nb;
    cas_ta    = TW'(ta);
    cas_tb    = TW'(tb);
    b_lvl     = lvl;
    cas_start = 1'b1;
    a0  = cyc;
    got = -1;
    na  = 0;
    nb  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cas_start = 1'b0;
      na += $countones(a_cs);
      nb += $countones(b_cs);
      if (a_done === 1'b1 && got < 0) begin
        got = cyc - a0;
        chk("cas_a_fail", 32'(a_fail), 32'(lit_afail));
        chk("cas_a_error", 32'(a_err), 32'(|lit_afail));
        chk("cas_a_busy_at_done", 32'(a_busy), 32'd0);
      end
    end
    chk("cas_done_cycle", 32'(got), 32'(lit_done));
    chk("cas_a_launches", 32'(na), 32'd3);
    chk("cas_b_launches", 32'(nb), 32'd3);
    chk("cas_b_fail", 32'(b_fail), 32'(lit_bfail));
    chk("cas_b_error", 32'(b_err), 32'(|lit_bfail));
    chk("cas_b_idle", 32'(b_busy), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    mode_i       = 1'b0;
    timeout_i    = '0;
    child_done_i = '0;
    cas_start    = 1'b0;
    cas_ta       = '0;
    cas_tb       = '0;
    b_lvl        = '0;
    dly          = '{-1, -1, -1, -1, -1};
    for (int i = 0; i < N; i++) pend[i] = -1;
    repeat (3) tick();
    chk("reset_child_start", 32'(child_start_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_error", 32'(error_o), 32'd0);
    chk("reset_fail", 32'(fail_mask_o), 32'd0);
    rst = 1'b0;
    tick();

    abort_run();
    run(1'b0, 8, '{1, 1, 1, 1, 1},   1'b0, 11, 5'b00000);
    run(1'b0, 4, '{1, 1, -1, 1, 1},  1'b0, 14, 5'b00100);
    run(1'b0, 4, '{3, 1, 6, 2, 4},   1'b0, 20, 5'b00100);
    run(1'b1, 6, '{2, 4, -1, 5, 6},  1'b0, 8,  5'b00100);
    run(1'b1, 0, '{1, 3, 2, 1, 5},   1'b0, 7,  5'b00000);
    run(1'b1, 3, '{0, 1, 1, 2, 3},   1'b0, 5,  5'b00001);
    run(1'b0, 0, '{2, 2, 2, 2, 2},   1'b1, 16, 5'b00000);
    run(1'b0, 1, '{-1, -1, -1, -1, -1}, 1'b0, 11, 5'b11111);
    no_timeout_run();

    cas_run(0, 8, 3'b111, 13, 3'b000, 3'b000);
    cas_run(0, 2, 3'b101, 14, 3'b000, 3'b010);
    cas_run(3, 0, 3'b111, 9,  3'b010, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/hier_node_sequencer.md
Name: hier_node_sequencer

Overview:
Parametrised hierarchy node that launches and supervises NUM_CHILDREN child blocks through a start/done handshake. It runs children in sequential order (0..N-1) or all in parallel, selected per run. A per-child timeout watchdog flags unresponsive children. Nodes cascade: a node's child_start_o/child_done_i connect to lower nodes' start_i/done_o, which builds a parametrised instance tree.

Parameters:
NUM_CHILDREN, 5, number of supervised child channels (1..32)
TIMEOUT_W, 8, width of the timeout counter and of timeout_i

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start_i  input  1  run request, sampled in IDLE only
mode_i  input  1  0 = sequential, 1 = parallel; captured on accepted start
timeout_i  input  TIMEOUT_W  max wait cycles per child (sequential) or per run (parallel); 0 = no timeout; captured on accepted start
child_start_o  output  NUM_CHILDREN  one-cycle start pulse per child
child_done_i  input  NUM_CHILDREN  child completion pulse or level
busy_o  output  1  high from the cycle after accepted start until done_o
done_o  output  1  one-cycle pulse at run end
error_o  output  1  OR of fail_mask_o, held until next accepted start
fail_mask_o  output  NUM_CHILDREN  bit i set = child i timed out; held until next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0; index, timeout counter, done-capture register and captured mode/timeout cleared. rst has priority in every state and aborts a run with no done_o.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE: start_i=1 -> capture mode_i and timeout_i, clear fail_mask_o, error_o and done-capture, set idx=0, go to LAUNCH. A start_i while not in IDLE is ignored and not queued.
- LAUNCH: sequential mode pulses child_start_o[idx]; parallel mode pulses all bits. Clear the timeout counter. Go to WAIT. busy_o=1.
- WAIT: child_done_i is sampled from the first WAIT cycle. A done in the LAUNCH cycle itself is ignored. The counter increments each WAIT cycle. Expiry means the counter equals timeout_t - 1 in a cycle with no completion, which gives exactly timeout_t WAIT cycles.
  - Sequential: child_done_i[idx]=1 or expiry. On expiry, set fail_mask_o[idx]. Then if idx==NUM_CHILDREN-1 go to FINISH; otherwise idx++ and go to LAUNCH. Done on a non-active channel is ignored.
  - Parallel: OR child_done_i into a sticky done-capture each cycle. All bits captured -> FINISH. On expiry, fail_mask_o = ~capture (including any done arriving in the expiry cycle) -> FINISH.
  - Done and expiry in the same cycle: done wins and no fail bit is set.
  - timeout_t=0: never expires; the node waits indefinitely.
- FINISH: done_o=1 for one cycle; error_o = |fail_mask_o (visible the same cycle as done_o); busy_o=0 in this cycle; return to IDLE. A start_i in the FINISH cycle is ignored. The next start is accepted from IDLE, so the minimum restart gap is 1 cycle.
- Sequential latency with immediate dones: start accepted at cycle 0 -> child_start_o[0] at cycle 1. Each child costs 2 cycles (LAUNCH + WAIT). done_o at cycle 2*N+1.
- Parallel latency: child_start_o all at cycle 1. done_o one cycle after the cycle in which the capture becomes all-ones.
- Counter width is TIMEOUT_W and it never wraps, because expiry halts counting. idx width is clog2(NUM_CHILDREN), minimum 1.

Test Plan:
- Reset mid-run: N=5, sequential, rst asserted while idx=2 -> next cycle all outputs 0, state IDLE, no done_o; a fresh start then begins at child 0.
- Sequential, all children respond: N=5, timeout_i=8, each child returns done 1 cycle after its start -> starts at cycles 1,3,5,7,9; done_o at cycle 11; fail_mask_o=0, error_o=0.
- Sequential timeout: child 2 never responds, timeout_i=4 -> child 2 WAIT lasts exactly 4 cycles; fail_mask_o=5'b00100, error_o=1; children 3 and 4 still launched.
- Parallel with mixed response: timeout_i=6; children 0,1,3 done at WAIT cycles 2,4,5, child 4 done in WAIT cycle 6 (same cycle as expiry), child 2 silent -> done_o after the 6th WAIT cycle; fail_mask_o=5'b00100.
- Ignored starts and no-timeout: start_i held high throughout a run -> exactly one run executes. timeout_i=0 with a silent child -> busy_o stays high for 1000 cycles with no done_o.
- Cascade: two nodes with N=3, node B driven from child 1 of node A -> A finishes only after B's done_o; B's fail does not set A's fail_mask unless A's own timeout expires.
